act_skew_feeder: RTL
====================

# act_skew_feeder

Input staging block placed directly upstream of the weight-stationary PE array (`basic_pe_array_ws`). It accepts one activation row (one element per array row-lane) per handshake and emits the diagonally skewed `a_vec` stream the array consumes: lane i is delayed i cycles relative to lane 0. It also emits a per-lane zero mask that drives PE clock gating, and frames each tile with a drain phase and a done pulse.

## Interface
- `size`, 8, activation element width in bits
- `row`, 8, number of array row-lanes (≥2)
- `clk`  input  1  single clock; all state changes on the rising edge
- `reset`  input  1  asynchronous, active-low; clears all state
- `in_data`  input  row*size  activation row; lane 0 in MSBs (`in_data[size*(row-i)-1 : size*(row-i-1)]` is lane i)
- `in_valid`  input  1  `in_data` and `in_last` valid
- `in_last`  input  1  marks final row of the tile
- `in_ready`  output  1  block can accept a row this cycle
- `flush`  input  1  synchronous clear of the skew pipeline and FSM
- `a_vec`  output  row*size  skewed activations to array; same lane packing as `in_data`
- `lane_valid`  output  row  bit i = lane i of `a_vec` carries an accepted element
- `zero_mask`  output  row  bit i = 1 when lane i of `a_vec` is zero (including bubbles)
- `busy`  output  1  FSM not in IDLE
- `out_done`  output  1  one-cycle pulse: last element of tile leaves lane row-1

## Operation
- Skew pipeline: lane i is a chain of i+1 registers (data + valid); triangular, total row*(row+1)/2 element registers. Every chain advances every cycle unconditionally (array has no stall).
- Injection per cycle: if `in_valid && in_ready`, lane i head loads element i of `in_data` with valid=1; otherwise loads zero with valid=0 (bubble).
- `zero_mask[i]` = (lane i output == 0); derived from the registered output, no extra delay.
- FSM states:
  - IDLE: `in_ready`=1. Accepted beat with `in_last`=0 → FEED; with `in_last`=1 → DRAIN (single-row tile).
  - FEED: `in_ready`=1. Accepted beat with `in_last`=1 → DRAIN. Cycles with `in_valid`=0 inject bubbles, stay in FEED.
  - DRAIN: `in_ready`=0; drain counter loaded with row-1 on entry, decrements each cycle; when it reaches 0 → IDLE with `out_done` asserted (registered) in that next cycle.
- `in_last` ignored when `in_valid`=0.
- `flush`=1: next edge clears all chain registers, counter, `out_done`, FSM → IDLE; `in_ready` remains 1 during the flush cycle but the beat is discarded (flush has priority over acceptance).
- Reset (`reset`=0) at any time, including mid-FEED/DRAIN: immediately clears everything; partially skewed data lost, no `out_done`.
- Back-to-back tiles: next tile accepted only after return to IDLE (`in_ready` rises the cycle `out_done` is high).

## Timing
- Reset values: `a_vec`=0, `lane_valid`=0, `zero_mask`=all ones, `in_ready`=1, `busy`=0, `out_done`=0.
- Latency: element i of a beat accepted at edge T appears on `a_vec` lane i after edge T+i (lane 0 visible the cycle after acceptance).
- Last beat accepted at edge T: DRAIN cycles occupy T..T+row-1; `out_done` high for exactly the cycle after edge T+row-1, i.e. the same cycle lane row-1 presents the last beat's element.
- `in_ready` combinational from FSM state only (no dependency on `in_valid`).
- Throughput: one row per cycle in FEED; tile of N rows occupies N+row-1 cycles from first accept to `out_done` (no bubbles), then one IDLE cycle overlapping `out_done`.

## Test plan
- Reset: drive `reset`=0 mid-stream → all outputs at reset values within the same cycle; `zero_mask`=8'hFF, `in_ready`=1.
- Skew: row=8, single beat lanes 1..8 with `in_last`=1 at edge T → lane i shows value i+1 only after edge T+i, zero elsewhere; `lane_valid` walks one-hot from bit 0 to bit 7; `out_done` pulse aligned with lane 7 = 8.
- Full tile: 32 back-to-back random rows (≈80% zeros, rest 1..255, matching array test density) → `a_vec` equals diagonal reference (lane i at cycle t = row t-i, element i); `out_done` 39 cycles after first accept; `in_ready`=0 for 7 cycles.
- Bubbles: drop `in_valid` for 3 cycles mid-tile → zero, `lane_valid`=0 diagonals inserted, subsequent data shifted by 3 cycles, `zero_mask` bits set on bubbles.
- Flush: assert `flush` in DRAIN with data in chains → next cycle `a_vec`=0, `busy`=0, no `out_done`, a new beat accepted the following cycle skews correctly.
- Zero mask: beat 8'h00,8'h05,8'h00,… → `zero_mask[0]`=1, `[1]`=0 when each element reaches its lane output.

Source files
------------

// File: rtl/act_skew_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : act_skew_feeder                                              |
// | Description : Activation staging ahead of the weight-stationary PE array.  |
// |               Accepts one activation row per handshake and emits a         |
// |               diagonally skewed stream (lane i delayed i cycles), a        |
// |               per-lane zero mask for PE clock gating, and tile framing     |
// |               with a drain phase and a done pulse.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module act_skew_feeder #(
    parameter int SIZE = 8,
    parameter int ROW  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ROW*SIZE-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                flush,
    output logic [ROW*SIZE-1:0] a_vec,
    output logic [ROW-1:0]      lane_valid,
    output logic [ROW-1:0]      zero_mask,
    output logic                busy,
    output logic                out_done
);

    // The drain counter only ever holds values 0..ROW-1.
    localparam int            c_CW         = $clog2(ROW);
    localparam logic [c_CW-1:0] c_DRAIN_LOAD = c_CW'(ROW - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [c_CW-1:0]   r_drain_cnt;
    logic              r_out_done;
    logic              w_accept;
    logic              w_drain_end;

    // Ready depends on the state alone so upstream never sees a combinational loop.
    assign in_ready = (r_state != S_DRAIN);
    assign busy     = (r_state != S_IDLE);
    assign out_done = r_out_done;
    assign w_accept = in_valid & in_ready;

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        w_drain_end  = 1'b0;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FEED: begin
                    if (w_accept) begin
                        w_next_state = in_last ? S_DRAIN : S_FEED;
                    end
                end
                S_DRAIN: begin
                    // Counter about to hit zero: the last element reaches lane ROW-1 now.
                    if (r_drain_cnt == c_CNT_ONE) begin
                        w_next_state = S_IDLE;
                        w_drain_end  = 1'b1;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // State register, drain counter and the registered done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_out_done  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_out_done <= w_drain_end;
            if (flush) begin
                r_drain_cnt <= '0;
            end else if ((r_state != S_DRAIN) && (w_next_state == S_DRAIN)) begin
                r_drain_cnt <= c_DRAIN_LOAD;
            end else if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt - c_CNT_ONE;
            end
        end
    end

    // Triangular skew pipeline: lane gi is a chain of gi+1 registers.
    for (genvar gi = 0; gi < ROW; gi++) begin : g_lane
        logic [SIZE-1:0] r_data [0:gi];
        logic            r_vld  [0:gi];

        // Head loads the accepted element or a bubble; the rest of the chain shifts every cycle.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= gi; s++) begin
                    r_data[s] <= '0;
                    r_vld[s]  <= 1'b0;
                end
            end else if (flush) begin
                for (int s = 0; s <= gi; s++) begin
                    r_data[s] <= '0;
                    r_vld[s]  <= 1'b0;
                end
            end else begin
                for (int s = gi; s > 0; s--) begin
                    r_data[s] <= r_data[s-1];
                    r_vld[s]  <= r_vld[s-1];
                end
                if (w_accept) begin
                    r_data[0] <= in_data[SIZE*(ROW-gi)-1 -: SIZE];
                    r_vld[0]  <= 1'b1;
                end else begin
                    r_data[0] <= '0;
                    r_vld[0]  <= 1'b0;
                end
            end
        end

        assign a_vec[SIZE*(ROW-gi)-1 -: SIZE] = r_data[gi];
        assign lane_valid[gi]                 = r_vld[gi];
        assign zero_mask[gi]                  = (r_data[gi] == '0);
    end

endmodule
`default_nettype wire
